// File: rtl/uart_rx_ovs_pkg.sv
// Shared definitions for the oversampling UART receiver and its baud tick generator.
// Optional feature macro: UART_RX_BREAK_DET_EN (adds the BREAK state).
package uart_rx_ovs_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
`ifdef UART_RX_BREAK_DET_EN
    , ST_BREAK
`endif
  } state_t;

  // Accumulator must hold CLOCK_FREQ-1 + BAUD_RATE*OVERSAMPLE without wrapping.
  function automatic int unsigned acc_width(input int unsigned clock_freq,
                                            input int unsigned baud_rate,
                                            input int unsigned oversample);
    return $clog2(clock_freq + baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Fractional phase-accumulator tick generator: BAUD_RATE*OVERSAMPLE ticks per second, no drift.
module uart_baud_tick
  import uart_rx_ovs_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 10_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned ACC_W = acc_width(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam logic [ACC_W-1:0] INC     = ACC_W'(BAUD_RATE * OVERSAMPLE);
  localparam logic [ACC_W-1:0] MODULUS = ACC_W'(CLOCK_FREQ);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;

  assign sum = acc + INC;

  // Advance phase; emit a tick and subtract the modulus on overflow past CLOCK_FREQ.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (sum >= MODULUS) begin
      acc  <= sum - MODULUS;
      tick <= 1'b1;
    end else begin
      acc  <= sum;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with majority vote, parity/stop checking and a ready/valid holding register.
// Optional feature macro: UART_RX_BREAK_DET_EN (break_det port and BREAK state).
module uart_rx_ovs
  import uart_rx_ovs_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 10_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
`ifdef UART_RX_BREAK_DET_EN
  ,
  output logic                 break_det
`endif
);

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_V0   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_V2   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [3:0]    N_DATA = 4'(DATA_BITS);
  localparam logic          HAS_PARITY = (PARITY == PARITY_ODD) || (PARITY == PARITY_EVEN);
  localparam logic          PAR_INV    = (PARITY == PARITY_ODD);
  localparam logic          LAST_STOP  = 1'(STOP_BITS - 1);

  state_t state, state_next;

  logic sync1, sync2, sync_d;
  logic tick;
  logic [SW-1:0] s;
  logic [2:0] samp;
  logic vote_evt, vote, start_det, bit_end;
  logic [DATA_BITS-1:0] shreg;
  logic [3:0] bit_cnt;
  logic stop_cnt, par_bad, stop_bad;
  logic start_go, shift_en, par_chk, stop_adv;
  logic done_good, done_perr, done_ferr;
`ifdef UART_RX_BREAK_DET_EN
  logic done_brk, all_zero;
  logic [SW-1:0] hi_cnt;
`endif

  assign start_det = sync_d & ~sync2;
  assign bit_end   = tick && (s == S_LAST);
  assign vote      = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);

  uart_baud_tick #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(start_go),
    .tick (tick)
  );

  // Two-flop synchronizer plus edge register; all idle high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      sync_d <= 1'b1;
    end else begin
      sync1  <= serial_in;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

  // Per-bit sample counter and three-sample capture around the bit centre.
  always_ff @(posedge clk) begin
    if (rst || start_go) begin
      s        <= '0;
      samp     <= 3'b111;
      vote_evt <= 1'b0;
    end else begin
      vote_evt <= tick && (s == S_V2);
      if (tick) begin
        s <= (s == S_LAST) ? '0 : s + 1'b1;
        if (s >= S_V0 && s <= S_V2) samp <= {samp[1:0], sync2};
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next state and frame control strobes.
  always_comb begin
    state_next = state;
    start_go   = 1'b0;
    shift_en   = 1'b0;
    par_chk    = 1'b0;
    stop_adv   = 1'b0;
    done_good  = 1'b0;
    done_perr  = 1'b0;
    done_ferr  = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    done_brk   = 1'b0;
`endif
    unique case (state)
      ST_IDLE: begin
        if (start_det) begin
          start_go   = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (vote_evt && vote) state_next = ST_IDLE;
        else if (bit_end)     state_next = ST_DATA;
      end
      ST_DATA: begin
        if (vote_evt) shift_en = 1'b1;
        if (bit_end && bit_cnt == N_DATA) state_next = HAS_PARITY ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (vote_evt) par_chk = 1'b1;
        if (bit_end) state_next = ST_STOP;
      end
      ST_STOP: begin
        // Complete at the last stop vote so a following start edge is never missed.
        if (vote_evt) begin
          if (stop_cnt == LAST_STOP) begin
            state_next = ST_IDLE;
`ifdef UART_RX_BREAK_DET_EN
            if (all_zero && !vote) begin
              done_brk   = 1'b1;
              state_next = ST_BREAK;
            end else
`endif
            if (stop_bad || !vote) done_ferr = 1'b1;
            else if (par_bad)      done_perr = 1'b1;
            else                   done_good = 1'b1;
          end else begin
            stop_adv = 1'b1;
          end
        end
      end
`ifdef UART_RX_BREAK_DET_EN
      ST_BREAK: begin
        if (tick && sync2 && hi_cnt == S_LAST) state_next = ST_IDLE;
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // Frame datapath: shift register, counters and latched error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_bad  <= 1'b0;
      stop_bad <= 1'b0;
    end else begin
      if (start_go) begin
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
        par_bad  <= 1'b0;
        stop_bad <= 1'b0;
      end
      if (shift_en) begin
        shreg   <= {vote, shreg[DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (par_chk) par_bad <= (vote != ((^shreg) ^ PAR_INV));
      if (stop_adv) begin
        stop_cnt <= 1'b1;
        if (!vote) stop_bad <= 1'b1;
      end
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  // Break tracking: all-zero frame flag and consecutive-high tick count while in BREAK.
  always_ff @(posedge clk) begin
    if (rst) begin
      all_zero <= 1'b0;
      hi_cnt   <= '0;
    end else begin
      if (start_go)                                  all_zero <= 1'b1;
      else if (vote_evt && vote && state != ST_IDLE) all_zero <= 1'b0;
      if (done_brk)                                  hi_cnt <= '0;
      else if (tick && state == ST_BREAK)            hi_cnt <= sync2 ? hi_cnt + 1'b1 : '0;
    end
  end
`endif

  // Registered outputs: holding register handshake and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      break_det  <= 1'b0;
`endif
    end else begin
      parity_err <= done_perr;
      frame_err  <= done_ferr;
      overrun    <= 1'b0;
      busy       <= (state_next != ST_IDLE);
`ifdef UART_RX_BREAK_DET_EN
      break_det  <= done_brk;
`endif
      if (done_good && (!data_valid || data_ready)) begin
        data_out   <= shreg;
        data_valid <= 1'b1;
      end else begin
        if (done_good) overrun <= 1'b1;
        if (data_valid && data_ready) data_valid <= 1'b0;
      end
    end
  end

endmodule
